imem_boot_loader: RTL

- Boot-time controller that owns the instruction-memory port.
- Receives a program as a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words.
- Writes each word into instruction memory, holding the core in reset until the load completes.
- After the load, hands the memory address port back to the core's fetch PC.

---
 rtl/imem_boot_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a length-prefixed byte program into instruction memory, then releases the core.
// Optional trailing XOR checksum byte is enabled by defining IMEM_BOOT_LOADER_CHKSUM_EN.
module imem_boot_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [31:0]       pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_RUN, S_ERR} state_t;
`endif

  state_t             state, state_nxt;
  logic [15:0]        len_q;
  logic [15:0]        len_new;
  logic [ADDR_W-1:0]  wptr;
  logic [1:0]         byte_idx;
  logic [23:0]        wbuf;
  logic               accept;
  logic               restart;
  logic               last_wr;
  logic               unused_pc;

`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
  logic [7:0]         xsum;
`endif

  assign accept    = rx_valid && rx_ready;
  assign restart   = start && (state == S_IDLE || state == S_RUN || state == S_ERR);
  assign len_new   = {rx_data, len_q[7:0]};
  // The write of the final word happens in the cycle after its 4th byte; leave DATA at the end of that cycle.
  assign last_wr   = mem_we && ((words_loaded + 16'd1) == len_q);
  assign unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN, S_ERR: if (start) state_nxt = S_LEN_LO;
      S_LEN_LO: if (accept) state_nxt = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_new == 16'd0) begin
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
            state_nxt = S_CHK;
`else
            state_nxt = S_RUN;
`endif
          end else if ({1'b0, len_new} > 17'(DEPTH)) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_wr) begin
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
          // A full-rate sender delivers the checksum byte during the final write cycle.
          if (accept) state_nxt = (rx_data == xsum) ? S_RUN : S_ERR;
          else        state_nxt = S_CHK;
`else
          state_nxt = S_RUN;
`endif
        end
      end
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
      S_CHK: if (accept) state_nxt = (rx_data == xsum) ? S_RUN : S_ERR;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    core_rst_n = 1'b0;
    mem_addr   = wptr;
    case (state)
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
      S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: begin
`else
      S_LEN_LO, S_LEN_HI, S_DATA: begin
`endif
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_RUN: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
        mem_addr   = pc[ADDR_W+1:2];
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q        <= '0;
      wptr         <= '0;
      words_loaded <= '0;
      byte_idx     <= '0;
      wbuf         <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
      xsum         <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (mem_we) begin
        wptr         <= wptr + 1'b1;
        words_loaded <= words_loaded + 16'd1;
      end
      if (restart) begin
        wptr         <= '0;
        words_loaded <= '0;
      end
      if (accept) begin
        case (state)
          S_LEN_LO: begin
            len_q[7:0] <= rx_data;
            byte_idx   <= '0;
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
            xsum       <= rx_data;
`endif
          end
          S_LEN_HI: begin
            len_q[15:8] <= rx_data;
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
            xsum        <= xsum ^ rx_data;
`endif
          end
          S_DATA: begin
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
            xsum     <= xsum ^ rx_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: wbuf[7:0]   <= rx_data;
              2'd1: wbuf[15:8]  <= rx_data;
              2'd2: wbuf[23:16] <= rx_data;
              default: begin
                mem_we    <= 1'b1;
                mem_wdata <= {rx_data, wbuf};
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
